// File: rtl/prog_seq_pkg.sv
// Shared types and default constants for the program sequencer.
// Optional watchdog: define PROG_SEQ_WATCHDOG_EN to enable the ERROR state.
package prog_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        RUN,
        FINISH,
        ERROR
    } state_t;

    localparam int unsigned DEF_PROG_W         = 2;
    localparam int unsigned DEF_INIT_CYCLES    = 2;
    localparam int unsigned DEF_CYC_W          = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;

    // All-ones source for saturation limits; counters slice their own width.
    localparam logic [63:0] SAT_ONES = '1;

endpackage

// File: rtl/prog_seq_cycle_counter.sv
// Saturating cycle counter with synchronous clear and count enable.
// Used by the sequencer for both the init hold time and the run length.
module prog_seq_cycle_counter
    import prog_seq_pkg::*;
#(
    parameter int unsigned W = DEF_CYC_W
) (
    input  logic         clock,
    input  logic         init,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] CNT_MAX = SAT_ONES[W-1:0];

    assign at_max = (count == CNT_MAX);

    // Count up while enabled, stick at the maximum, clear on request.
    always_ff @(posedge clock) begin
        if (init || clr) begin
            count <= '0;
        end else if (en && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Sequences the processor core through a batch of programs: for each one
// it holds proc_init, pulses proc_restart, then times the run to proc_done.
// Optional watchdog: define PROG_SEQ_WATCHDOG_EN to trap runs that exceed
// TIMEOUT_CYCLES in the ERROR state; otherwise err is tied low.
module program_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned PROG_W         = DEF_PROG_W,
    parameter int unsigned INIT_CYCLES    = DEF_INIT_CYCLES,
    parameter int unsigned CYC_W          = DEF_CYC_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clock,
    input  logic              init,
    input  logic              start,
    input  logic              abort,
    input  logic [PROG_W:0]   num_progs,
    input  logic              proc_done,
    output logic              proc_init,
    output logic              proc_restart,
    output logic [PROG_W-1:0] prog_sel,
    output logic              busy,
    output logic              run_done,
    output logic [CYC_W-1:0]  run_cycles,
    output logic              all_done,
    output logic              err
);

    localparam logic [CYC_W-1:0] LOAD_LAST = CYC_W'(INIT_CYCLES - 1);

    state_t            state;
    logic [PROG_W-1:0] idx;
    logic [PROG_W:0]   nprogs;
    logic [CYC_W-1:0]  cnt;
    logic [CYC_W-1:0]  cnt_inc;
    logic              cnt_sat;
    logic              cnt_en;
    logic              cnt_clr;
    logic              in_busy;
    logic              load_last;
    logic              last_prog;

    // One counter serves both LOAD and RUN; it is cleared whenever the FSM
    // leaves either state so each phase starts counting from zero.
    prog_seq_cycle_counter #(
        .W (CYC_W)
    ) u_cnt (
        .clock  (clock),
        .init   (init),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .count  (cnt),
        .at_max (cnt_sat)
    );

    assign in_busy   = (state == LOAD) || (state == LAUNCH) || (state == RUN);
    assign cnt_en    = (state == LOAD) || (state == RUN);
    assign load_last = (cnt == LOAD_LAST);
    assign last_prog = ({1'b0, idx} == (nprogs - 1'b1));
    assign cnt_inc   = cnt_sat ? cnt : cnt + 1'b1;
    assign cnt_clr   = !cnt_en || abort
                     || ((state == LOAD) && load_last)
                     || ((state == RUN) && proc_done);

`ifdef PROG_SEQ_WATCHDOG_EN
    localparam logic [CYC_W-1:0] WD_LIMIT = CYC_W'(TIMEOUT_CYCLES);

    logic wd_hit;

    // cnt_inc is the number of RUN cycles elapsed including the current one.
    assign wd_hit = (cnt_inc >= WD_LIMIT);
`else
    assign err = 1'b0;

    // The watchdog limit has no effect in this build.
    if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
    end
`endif

    // Batch state machine; every output is registered from the next state.
    always_ff @(posedge clock) begin
        if (init) begin
            state        <= IDLE;
            idx          <= '0;
            nprogs       <= '0;
            proc_init    <= 1'b0;
            proc_restart <= 1'b0;
            prog_sel     <= '0;
            busy         <= 1'b0;
            run_done     <= 1'b0;
            run_cycles   <= '0;
            all_done     <= 1'b0;
`ifdef PROG_SEQ_WATCHDOG_EN
            err          <= 1'b0;
`endif
        end else begin
            run_done <= 1'b0;
            if (!in_busy) begin
                if (start) begin
                    nprogs <= num_progs;
                    idx    <= '0;
`ifdef PROG_SEQ_WATCHDOG_EN
                    err    <= 1'b0;
`endif
                    if (num_progs == '0) begin
                        state    <= FINISH;
                        all_done <= 1'b1;
                    end else begin
                        state     <= LOAD;
                        all_done  <= 1'b0;
                        prog_sel  <= '0;
                        proc_init <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
            end else if (abort) begin
                state        <= IDLE;
                proc_init    <= 1'b0;
                proc_restart <= 1'b0;
                busy         <= 1'b0;
            end else begin
                unique case (state)
                    LOAD: begin
                        if (load_last) begin
                            state        <= LAUNCH;
                            proc_init    <= 1'b0;
                            proc_restart <= 1'b1;
                        end
                    end
                    LAUNCH: begin
                        state        <= RUN;
                        proc_restart <= 1'b0;
                    end
                    RUN: begin
                        if (proc_done) begin
                            run_cycles <= cnt_inc;
                            run_done   <= 1'b1;
                            if (last_prog) begin
                                state    <= FINISH;
                                busy     <= 1'b0;
                                all_done <= 1'b1;
                            end else begin
                                idx       <= idx + 1'b1;
                                prog_sel  <= idx + 1'b1;
                                state     <= LOAD;
                                proc_init <= 1'b1;
                            end
                        end
`ifdef PROG_SEQ_WATCHDOG_EN
                        else if (wd_hit) begin
                            state <= ERROR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized self-checking bench for program_sequencer. Each batch is laid
// out as an expected per-cycle trace computed from phase lengths
// (INIT_CYCLES load cycles, one launch cycle, d run cycles per program).
module tb_program_sequencer;

    localparam int unsigned PROG_W      = 2;
    localparam int unsigned INIT_CYCLES = 2;
    localparam int unsigned CYC_W       = 16;
    localparam int unsigned TIMEOUT     = 10;
    localparam int          MAXS        = 128;

    typedef logic [PROG_W:0]   np_t;
    typedef logic [PROG_W-1:0] sel_t;
    typedef logic [CYC_W-1:0]  cyc_t;

    typedef struct packed {
        logic pinit;
        logic prst;
        sel_t sel;
        logic busy;
        logic rdone;
        cyc_t rcyc;
        logic alldone;
        logic err;
    } obs_t;

    logic        clock = 1'b0;
    logic        init;
    logic        start;
    logic        abort;
    np_t         num_progs;
    logic        proc_done;
    logic        proc_init;
    logic        proc_restart;
    sel_t        prog_sel;
    logic        busy;
    logic        run_done;
    cyc_t        run_cycles;
    logic        all_done;
    logic        err;
    obs_t        got;

    always #5 clock = ~clock;

    program_sequencer #(
        .PROG_W         (PROG_W),
        .INIT_CYCLES    (INIT_CYCLES),
        .CYC_W          (CYC_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock        (clock),
        .init         (init),
        .start        (start),
        .abort        (abort),
        .num_progs    (num_progs),
        .proc_done    (proc_done),
        .proc_init    (proc_init),
        .proc_restart (proc_restart),
        .prog_sel     (prog_sel),
        .busy         (busy),
        .run_done     (run_done),
        .run_cycles   (run_cycles),
        .all_done     (all_done),
        .err          (err)
    );

    assign got = {proc_init, proc_restart, prog_sel, busy, run_done,
                  run_cycles, all_done, err};

    obs_t exp_a [MAXS];
    logic st_a  [MAXS];
    logic ab_a  [MAXS];
    logic in_a  [MAXS];
    logic pd_a  [MAXS];
    np_t  np_a  [MAXS];
    int   dly   [4];

    sel_t m_sel = '0;
    cyc_t m_rc  = '0;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, want);
        end
    endtask

    // Build the expected trace for one batch, play it, update the model.
    // dly[p]==0 means program p never finishes (watchdog case).
    // cut_kind: 0 none, 1 abort at step cut_at, 2 init at step cut_at.
    task automatic run_batch(input string name, input int n, input int noise,
                             input int cut_at, input int cut_kind);
        obs_t e;
        int   b;
        int   len;
        int   ld;
        sel_t sel;
        cyc_t rc;
        bit   hung;

        sel  = m_sel;
        rc   = m_rc;
        hung = 1'b0;
        for (int s = 0; s < MAXS; s++) begin
            st_a[s]  = 1'b0;
            ab_a[s]  = 1'b0;
            in_a[s]  = 1'b0;
            pd_a[s]  = 1'($urandom_range(0, 1));
            np_a[s]  = np_t'($urandom_range(0, 4));
            exp_a[s] = '0;
        end
        st_a[0] = 1'b1;
        np_a[0] = np_t'(n);

        b = 0;
        for (int p = 0; p < n && !hung; p++) begin
            ld = INIT_CYCLES;
            for (int k = 0; k < ld; k++) begin
                e = '0;
                e.pinit = 1'b1;
                e.sel   = sel_t'(p);
                e.busy  = 1'b1;
                e.rdone = (k == 0) && (p > 0);
                e.rcyc  = rc;
                exp_a[b+k] = e;
            end
            e = '0;
            e.prst = 1'b1;
            e.sel  = sel_t'(p);
            e.busy = 1'b1;
            e.rcyc = rc;
            exp_a[b+ld] = e;
            for (int s = b + 1; s <= b + ld + 1; s++)
                pd_a[s] = (noise == 0) ? 1'b0 : (noise == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            e = '0;
            e.sel  = sel_t'(p);
            e.busy = 1'b1;
            e.rcyc = rc;
            if (dly[p] == 0) begin
                for (int j = 1; j <= int'(TIMEOUT); j++) exp_a[b+ld+j] = e;
                for (int s = b + ld + 2; s <= b + ld + int'(TIMEOUT) + 1; s++) pd_a[s] = 1'b0;
                b = b + ld + int'(TIMEOUT) + 1;
                e = '0;
                e.sel  = sel_t'(p);
                e.rcyc = rc;
                e.err  = 1'b1;
                exp_a[b] = e;
                hung = 1'b1;
            end else begin
                for (int j = 1; j <= dly[p]; j++) exp_a[b+ld+j] = e;
                for (int s = b + ld + 2; s <= b + ld + dly[p]; s++) pd_a[s] = 1'b0;
                pd_a[b+ld+dly[p]+1] = 1'b1;
                rc = cyc_t'(dly[p]);
                b  = b + ld + dly[p] + 1;
            end
            sel = sel_t'(p);
        end
        if (!hung) begin
            e = '0;
            e.alldone = 1'b1;
            e.rdone   = (n > 0);
            e.rcyc    = rc;
            e.sel     = sel;
            exp_a[b] = e;
        end
        // Steps 1..b sample a busy state, so start there must be ignored.
        for (int s = 1; s <= b; s++) st_a[s] = 1'($urandom_range(0, 1));
        e = exp_a[b];
        e.rdone = 1'b0;
        exp_a[b+1] = e;
        len = b + 2;

        if (cut_kind != 0 && cut_at >= 1 && cut_at <= b) begin
            e = '0;
            if (cut_kind == 1) begin
                ab_a[cut_at] = 1'b1;
                pd_a[cut_at] = 1'b1;
                e.sel  = exp_a[cut_at-1].sel;
                e.rcyc = exp_a[cut_at-1].rcyc;
            end else begin
                in_a[cut_at] = 1'b1;
            end
            st_a[cut_at+1]  = 1'b0;
            exp_a[cut_at]   = e;
            exp_a[cut_at+1] = e;
            len = cut_at + 2;
        end

        for (int s = 0; s < len; s++) begin
            @(negedge clock);
            init      = in_a[s];
            start     = st_a[s];
            abort     = ab_a[s];
            proc_done = pd_a[s];
            num_progs = np_a[s];
            @(posedge clock);
            #1;
            check($sformatf("%s.s%0d", name, s), 32'(got), 32'(exp_a[len > s ? s : 0]));
        end
        m_sel = exp_a[len-1].sel;
        m_rc  = exp_a[len-1].rcyc;
    endtask

    initial begin
        int n;
        int kind;

        init      = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        proc_done = 1'b0;
        num_progs = '0;
        repeat (2) begin
            @(posedge clock);
            #1;
            check("reset", 32'(got), 32'd0);
        end

        dly = '{3, 4, 1, 1};
        run_batch("two", 2, 0, 0, 0);

        dly = '{5, 7, 9, 1};
        run_batch("three", 3, 0, 0, 0);

        run_batch("zero", 0, 2, 0, 0);

        dly = '{1, 1, 1, 1};
        run_batch("done_early", 1, 1, 0, 0);

        // Abort on the cycle program 0 reports done: INIT_CYCLES + 4 + 1.
        dly = '{4, 3, 3, 3};
        run_batch("abort", 3, 2, INIT_CYCLES + 5, 1);

        dly = '{6, 2, 2, 2};
        run_batch("midinit", 2, 2, 5, 2);

`ifdef PROG_SEQ_WATCHDOG_EN
        dly = '{0, 1, 1, 1};
        run_batch("wd_trip", 2, 0, 0, 0);
        dly = '{TIMEOUT, 2, 1, 1};
        run_batch("wd_donewins", 1, 2, 0, 0);
        dly = '{3, 2, 1, 1};
        run_batch("wd_after", 2, 2, 0, 0);
`endif

        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 4);
            for (int p = 0; p < 4; p++) dly[p] = $urandom_range(1, TIMEOUT);
            kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            run_batch($sformatf("rnd%0d", t), n, 2, $urandom_range(1, 30), kind);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
